// File: rtl/instruction_decode.sv
// RV32I instruction decode stage.
// Holds the IF/ID register, the 32x32 register file and the ID/EX output register.
// Detects load-use hazards and stalls fetch. A taken branch (pc_src) flushes both registers.
// Ports:
//   clk, rst               rising-edge clock and synchronous active-high reset
//   if_instruction, if_pc  fetched instruction and its PC
//   pc_src                 EX-stage redirect; flushes IF/ID and ID/EX
//   wb_we, wb_rd, wb_data  register-file write port from writeback
//   stall                  combinational load-use stall to fetch
//   ex_*                   registered decode results feeding EX
module instruction_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_instruction,
    input  logic [XLEN-1:0] if_pc,
    input  logic            pc_src,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_pc_src_a,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            pc_src_a;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            illegal;
    } idex_t;

    // ALU operation for OP / OP-IMM from funct3; alt selects SUB/SRA where allowed
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic sub_en,
                                               input logic sra_en);
        case (f3)
            3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    idex_t           ex_q, ex_d;
    idex_t           dec;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            rs1_used, rs2_used;

    assign opcode = ifid_instr_q[6:0];
    assign rd     = ifid_instr_q[11:7];
    assign funct3 = ifid_instr_q[14:12];
    assign rs1    = ifid_instr_q[19:15];
    assign rs2    = ifid_instr_q[24:20];

    assign imm_i = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    assign imm_s = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
    assign imm_b = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
    assign imm_u = {ifid_instr_q[31:12], 12'b0};
    assign imm_j = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                    ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};

    // Register-file reads with write-through bypass from writeback
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0) begin
            rs1_data = (wb_we && (wb_rd == rs1)) ? wb_data : regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_data = (wb_we && (wb_rd == rs2)) ? wb_data : regs_q[rs2];
        end
    end

    // Register-file write; x0 is never written
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_rd != 5'd0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    // Which source registers the IF/ID instruction actually reads
    always_comb begin
        rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        rs2_used = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    end

    // Load-use hazard against the load sitting in ID/EX; a redirect cancels it
    assign stall = !pc_src && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ifid_valid_q &&
                   ((rs1_used && (ex_q.rd == rs1)) || (rs2_used && (ex_q.rd == rs2)));

    // Control and immediate decode of the IF/ID instruction
    always_comb begin
        dec          = '0;
        dec.valid    = ifid_valid_q;
        dec.pc       = ifid_pc_q;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.funct3   = funct3;
        case (opcode)
            OPC_LUI: begin
                dec.imm       = imm_u;
                dec.alu_op    = ALU_PASS_B;
                dec.alu_src   = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_AUIPC: begin
                dec.imm       = imm_u;
                dec.alu_src   = 1'b1;
                dec.pc_src_a  = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_JAL: begin
                dec.imm       = imm_j;
                dec.alu_src   = 1'b1;
                dec.pc_src_a  = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_JALR: begin
                dec.imm       = imm_i;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_BRANCH: begin
                dec.imm       = imm_b;
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm       = imm_i;
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_STORE: begin
                dec.imm       = imm_s;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                dec.imm       = imm_i;
                dec.alu_op    = alu_from_f3(funct3, 1'b0, ifid_instr_q[30]);
                dec.alu_src   = 1'b1;
                dec.reg_write = (rd != 5'd0);
            end
            OPC_OP: begin
                dec.alu_op    = alu_from_f3(funct3, ifid_instr_q[30], ifid_instr_q[30]);
                dec.reg_write = (rd != 5'd0);
            end
            default: begin
                dec.illegal   = 1'b1;
            end
        endcase
        // A flushed/empty IF/ID slot issues as a clean bubble
        if (!ifid_valid_q) begin
            dec = '0;
        end
    end

    // IF/ID next state: flush, then hold on stall, else capture from fetch
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (pc_src) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = if_instruction;
            ifid_pc_d    = if_pc;
        end
    end

    // ID/EX next state: bubble on flush or stall
    always_comb begin
        ex_d = dec;
        if (pc_src || stall) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ex_q         <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ex_q         <= ex_d;
            regs_q       <= regs_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_funct3    = ex_q.funct3;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_pc_src_a  = ex_q.pc_src_a;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_jalr      = ex_q.jalr;
    assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus random
// instruction streams checked against a behavioural pipeline/regfile model.
module tb_instruction_decode;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_instruction = NOP;
    logic [31:0] if_pc = '0;
    logic        pc_src = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_pc_src_a, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_branch, ex_jump, ex_jalr, ex_illegal;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_pc(if_pc),
        .pc_src(pc_src), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_pc_src_a(ex_pc_src_a),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        src, pca, mr, mw, rw, br, jmp, jalr, ill;
        logic        ck_imm, ck_r1, ck_r2, ck_jmp, ck_fld;
    } ex_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic        m_ifid_valid;
    logic [31:0] m_ifid_instr, m_ifid_pc;
    logic [31:0] m_regs [32];
    ex_t         m_ex;
    logic        obs_stall;
    logic [3:0]  aluf [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    logic [6:0]  op_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input int unsigned v, input int bits);
        if (((v >> (bits - 1)) & 1) != 0) return 32'(v - (32'd1 << bits));
        return 32'(v);
    endfunction

    function automatic logic rs1_used(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic logic rs2_used(input logic [6:0] op);
        return op == 7'h63 || op == 7'h23 || op == 7'h33;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] d);
        if (a == 0) return 32'd0;
        if (we && wrd == a) return d;
        return m_regs[a];
    endfunction

    // Reference decode, written directly from the instruction-set rules
    function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1d, input logic [31:0] r2d);
        ex_t         e;
        int unsigned u;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        rdnz;
        u    = ins;
        op   = ins[6:0];
        f3   = ins[14:12];
        rdnz = (ins[11:7] != 0);
        e    = '0;
        e.valid = 1'b1; e.pc = pc; e.r1d = r1d; e.r2d = r2d;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        e.ck_imm = 1'b1; e.ck_jmp = 1'b1; e.ck_fld = 1'b1;
        case (op)
            7'h37: begin e.imm = u & 32'hFFFFF000; e.alu = 4'd10; e.src = 1; e.rw = rdnz; end
            7'h17: begin e.imm = u & 32'hFFFFF000; e.src = 1; e.pca = 1; e.rw = rdnz; end
            7'h6F: begin
                e.imm = sext(((u >> 31) << 20) | (((u >> 12) & 255) << 12) |
                             (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
                e.src = 1; e.pca = 1; e.jmp = 1; e.rw = rdnz;
            end
            7'h67: begin e.imm = sext(u >> 20, 12); e.src = 1; e.jalr = 1; e.rw = rdnz; e.ck_jmp = 0; end
            7'h63: begin
                e.imm = sext(((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                             (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
                e.alu = 4'd1; e.br = 1;
            end
            7'h03: begin e.imm = sext(u >> 20, 12); e.src = 1; e.mr = 1; e.rw = rdnz; end
            7'h23: begin e.imm = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12); e.src = 1; e.mw = 1; end
            7'h13: begin
                e.imm = sext(u >> 20, 12); e.src = 1; e.rw = rdnz;
                e.alu = aluf[f3] + ((f3 == 3'd5 && ins[30]) ? 4'd1 : 4'd0);
            end
            7'h33: begin
                e.alu = aluf[f3] + (((f3 == 3'd0 || f3 == 3'd5) && ins[30]) ? 4'd1 : 4'd0);
                e.rw = rdnz; e.ck_imm = 0;
            end
            default: begin e.ill = 1; e.ck_imm = 0; e.ck_fld = 0; end
        endcase
        e.ck_r1 = e.ck_fld && rs1_used(op);
        e.ck_r2 = e.ck_fld && rs2_used(op);
        return e;
    endfunction

    function automatic logic model_stall(input logic ps);
        logic [6:0] op;
        op = m_ifid_instr[6:0];
        return !ps && m_ex.valid && m_ex.mr && m_ex.rd != 0 && m_ifid_valid &&
               ((rs1_used(op) && m_ex.rd == m_ifid_instr[19:15]) ||
                (rs2_used(op) && m_ex.rd == m_ifid_instr[24:20]));
    endfunction

    task automatic check_ex();
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
        chk("ex_illegal", 32'(ex_illegal), 32'(m_ex.ill));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_ex.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m_ex.mw));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
        chk("ex_branch", 32'(ex_branch), 32'(m_ex.br));
        if (!m_ex.valid || m_ex.ck_jmp) chk("ex_jump", 32'(ex_jump), 32'(m_ex.jmp));
        if (m_ex.valid) begin
            chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex.alu));
            chk("ex_alu_src", 32'(ex_alu_src), 32'(m_ex.src));
            chk("ex_pc_src_a", 32'(ex_pc_src_a), 32'(m_ex.pca));
            chk("ex_jalr", 32'(ex_jalr), 32'(m_ex.jalr));
            if (m_ex.ck_fld) begin
                chk("ex_pc", ex_pc, m_ex.pc);
                chk("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
                chk("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
                chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
                chk("ex_funct3", 32'(ex_funct3), 32'(m_ex.f3));
            end
            if (m_ex.ck_imm) chk("ex_imm", ex_imm, m_ex.imm);
            if (m_ex.ck_r1) chk("ex_rs1_data", ex_rs1_data, m_ex.r1d);
            if (m_ex.ck_r2) chk("ex_rs2_data", ex_rs2_data, m_ex.r2d);
        end
    endtask

    task automatic model_reset();
        m_ifid_valid = 1'b0;
        m_ifid_instr = NOP;
        m_ifid_pc    = '0;
        m_ex         = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // One clock: drive at negedge, check, advance the model, pass the posedge
    task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ps, input logic we, input logic [4:0] wrd,
                         input logic [31:0] d);
        ex_t  nx;
        logic ms;
        rst = r; if_instruction = ins; if_pc = pc; pc_src = ps;
        wb_we = we; wb_rd = wrd; wb_data = d;
        #1;
        check_ex();
        ms = model_stall(ps);
        obs_stall = stall;
        chk("stall", 32'(stall), 32'(ms));
        if (r) begin
            model_reset();
        end else begin
            if (ps || ms || !m_ifid_valid) nx = '0;
            else nx = ref_decode(m_ifid_instr, m_ifid_pc,
                                 rd_reg(m_ifid_instr[19:15], we, wrd, d),
                                 rd_reg(m_ifid_instr[24:20], we, wrd, d));
            if (ps) begin
                m_ifid_valid = 1'b0;
                m_ifid_instr = NOP;
            end else if (!ms) begin
                m_ifid_valid = 1'b1;
                m_ifid_instr = ins;
                m_ifid_pc    = pc;
            end
            if (we && wrd != 0) m_regs[wrd] = d;
            m_ex = nx;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins);
        cycle(1'b0, ins, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = op_tab[$urandom_range(0, 11)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    localparam logic [31:0] LW_X2    = {12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011};
    localparam logic [31:0] ADD_DEP  = {7'd0, 5'd4, 5'd2, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] ADD_IND  = {7'd0, 5'd5, 5'd4, 3'b000, 5'd3, 7'b0110011};

    initial begin
        model_reset();
        @(negedge clk);
        cycle(1'b1, NOP, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, NOP, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_ex_rs1_data", ex_rs1_data, 32'd0);
        chk("rst_ex_alu_src", 32'(ex_alu_src), 32'd0);
        chk("rst_stall", 32'(obs_stall), 32'd0);

        // Every register reads zero after reset
        for (int i = 1; i <= 32; i++) begin
            issue({7'd0, 5'(i % 32), 5'(i % 32), 3'b110, 5'd0, 7'b0110011});
            if (i >= 2) chk("reg_reset_zero", ex_rs1_data, 32'd0);
        end

        // Write-through bypass, x0 write ignored, stored value persists
        issue({7'd0, 5'd0, 5'd5, 3'b000, 5'd3, 7'b0110011});
        cycle(1'b0, NOP, 32'h104, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("bypass", ex_rs1_data, 32'hDEADBEEF);
        issue({7'd0, 5'd0, 5'd0, 3'b000, 5'd3, 7'b0110011});
        cycle(1'b0, NOP, 32'h104, 1'b0, 1'b1, 5'd0, 32'h00001234);
        chk("x0_zero", ex_rs1_data, 32'd0);
        issue({7'd0, 5'd0, 5'd5, 3'b000, 5'd3, 7'b0110011});
        issue(NOP);
        chk("x5_stored", ex_rs1_data, 32'hDEADBEEF);

        // Immediates
        issue({1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1110, 1'b1, 7'b1100011});
        issue(NOP);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_branch", 32'(ex_branch), 32'd1);
        chk("beq_alu", 32'(ex_alu_op), 32'd1);
        issue(32'h001000EF);
        issue(NOP);
        chk("jal_imm", ex_imm, 32'h00000800);
        chk("jal_jump", 32'(ex_jump), 32'd1);
        chk("jal_pca", 32'(ex_pc_src_a), 32'd1);
        issue({20'h12345, 5'd7, 7'b0110111});
        issue(NOP);
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_alu", 32'(ex_alu_op), 32'd10);

        // Load-use hazard
        issue(LW_X2);
        issue(ADD_DEP);
        issue(NOP);
        chk("lu_stall", 32'(obs_stall), 32'd1);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        issue(NOP);
        chk("lu_release", 32'(obs_stall), 32'd0);
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rd", 32'(ex_rd), 32'd3);
        issue(LW_X2);
        issue(ADD_IND);
        issue(NOP);
        chk("nohaz_stall", 32'(obs_stall), 32'd0);
        chk("nohaz_valid", 32'(ex_valid), 32'd1);

        // Flush beats hazard
        issue(LW_X2);
        issue(ADD_DEP);
        cycle(1'b0, NOP, 32'h200, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush_stall", 32'(obs_stall), 32'd0);
        chk("flush_ex", 32'(ex_valid), 32'd0);
        issue(NOP);
        chk("flush_ifid", 32'(ex_valid), 32'd0);
        issue(NOP);

        // Illegal opcode and SRAI
        issue({25'h1ABCDE, 7'b1111111});
        issue(NOP);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_rw", 32'(ex_reg_write), 32'd0);
        chk("ill_mw", 32'(ex_mem_write), 32'd0);
        issue({7'b0100000, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011});
        issue(NOP);
        chk("srai_alu", 32'(ex_alu_op), 32'd7);
        chk("srai_imm", 32'(ex_imm[4:0]), 32'd3);

        // Random streams
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 299) == 0), rand_instr(), $urandom,
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
